// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NUM_CH = 4;

  localparam logic [SEL_W-1:0] CH_A = 2'd0;
  localparam logic [SEL_W-1:0] CH_B = 2'd1;
  localparam logic [SEL_W-1:0] CH_C = 2'd2;
  localparam logic [SEL_W-1:0] CH_D = 2'd3;

  typedef enum logic {
    StIdle,
    StDwell
  } state_e;

  // Index of the lowest set bit; CH_A when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = CH_A;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational finder for the next enabled channel after cur.
// wrap is set when no enabled channel lies above cur; nxt then points at the lowest one.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap
);

  // Scan downwards so the last hit is the lowest enabled index above cur.
  always_comb begin
    nxt  = lowest_set(mask);
    wrap = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) begin
        nxt  = SEL_W'(i);
        wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Round-robin select driver for a 4:1 mux with programmable dwell and frame assembly.
// Channel count is fixed at NUM_CH = 4 by mux_scan_pkg.
// Optional build macro MUX_SCAN_FRAME_CNT_EN adds an 8-bit frame counter output.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic               mux_out,
  output logic [SEL_W-1:0]   slc,
  output logic               sample_vld,
  output logic [NUM_CH-1:0]  frame,
  output logic               frame_vld,
  output logic               busy
`ifdef MUX_SCAN_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  state_e              state_q;
  logic [DWELL_W-1:0]  cnt_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [NUM_CH-1:0]   acc_q;
  logic [NUM_CH-1:0]   acc_merged;
  logic [SEL_W-1:0]    nxt_ch;
  logic                nxt_wrap;
  logic                stop;
  logic                sample_hit;

  mux_scan_next_ch u_next_ch (
    .cur  (slc),
    .mask (ch_mask),
    .nxt  (nxt_ch),
    .wrap (nxt_wrap)
  );

  // Sample/frame pulses decode from state and counter; a stop request suppresses both.
  always_comb begin
    stop       = !en || (ch_mask == '0);
    sample_hit = (state_q == StDwell) && (cnt_q == dwell_q) && !stop;
    sample_vld = sample_hit;
    frame_vld  = sample_hit && nxt_wrap;
  end

  // Accumulator with the current sample merged into the selected channel's bit.
  always_comb begin
    acc_merged = acc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(slc) == i) acc_merged[i] = mux_out;
    end
  end

  // Scan FSM with registered select, frame and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dwell_q   <= '0;
      acc_q     <= '0;
      slc       <= CH_A;
      frame     <= '0;
      busy      <= 1'b0;
`ifdef MUX_SCAN_FRAME_CNT_EN
      frame_cnt <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!stop) begin
            state_q <= StDwell;
            busy    <= 1'b1;
            slc     <= lowest_set(ch_mask);
            cnt_q   <= '0;
            dwell_q <= dwell;
            acc_q   <= '0;
          end
        end
        StDwell: begin
          if (stop) begin
            // Partial frame (and any sample due this cycle) is dropped.
            state_q   <= StIdle;
            busy      <= 1'b0;
            slc       <= CH_A;
            cnt_q     <= '0;
            acc_q     <= '0;
`ifdef MUX_SCAN_FRAME_CNT_EN
            frame_cnt <= '0;
`endif
          end else if (sample_hit) begin
            slc     <= nxt_ch;
            cnt_q   <= '0;
            dwell_q <= dwell;
            if (nxt_wrap) begin
              frame     <= acc_merged;
              acc_q     <= '0;
`ifdef MUX_SCAN_FRAME_CNT_EN
              frame_cnt <= frame_cnt + 8'd1;
`endif
            end else begin
              acc_q <= acc_merged;
            end
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer. The reference model predicts the select,
// pulses and frame from the enabled-channel list, dwell and frame period arithmetic.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] dwell;
  logic [3:0] ch_mask;
  logic       mux_out;
  logic [1:0] slc;
  logic       sample_vld;
  logic [3:0] frame;
  logic       frame_vld;
  logic       busy;
`ifdef MUX_SCAN_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  // Environment mux: channel data selected by the DUT's select.
  logic [3:0] data;
  assign mux_out = data[slc];

  int         n_pass  = 0;
  int         n_total = 0;
  logic [3:0] model_frame = 4'h0;

  mux_scan_sequencer #(
    .DWELL_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
    .mux_out    (mux_out),
    .slc        (slc),
    .sample_vld (sample_vld),
    .frame      (frame),
    .frame_vld  (frame_vld),
    .busy       (busy)
`ifdef MUX_SCAN_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scan for 'cycles' cycles with fixed mask/dwell/data, then drop en on the next cycle.
  task automatic run_scan(input logic [3:0] m, input int d, input logic [3:0] dat,
                          input int cycles);
    int ch[4];
    int n;
    int hold;
    int p;
    n    = 0;
    hold = d + 1;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        ch[n] = i;
        n++;
      end
    end
    p = n * hold;
    @(negedge clk);
    ch_mask = m;
    dwell   = 4'(d);
    data    = dat;
    en      = 1'b1;
    #1;
    check("start_busy", 32'(busy), 32'd0);
    check("start_svld", 32'(sample_vld), 32'd0);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      #1;
      check("slc", 32'(slc), 32'(ch[(k / hold) % n]));
      check("sample_vld", 32'(sample_vld), 32'((k % hold) == hold - 1));
      check("frame_vld", 32'(frame_vld), 32'((k % p) == p - 1));
      check("busy", 32'(busy), 32'd1);
      check("frame", 32'(frame), 32'((k >= p) ? (dat & m) : model_frame));
`ifdef MUX_SCAN_FRAME_CNT_EN
      check("frame_cnt", 32'(frame_cnt), 32'((k / p) % 256));
`endif
    end
    // Drop cycle: any pending sample or frame completion is discarded.
    @(negedge clk);
    en = 1'b0;
    #1;
    check("drop_svld", 32'(sample_vld), 32'd0);
    check("drop_fvld", 32'(frame_vld), 32'd0);
    if (cycles / p > 0) model_frame = dat & m;
    @(negedge clk);
    #1;
    check("idle_slc", 32'(slc), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_frame", 32'(frame), 32'(model_frame));
`ifdef MUX_SCAN_FRAME_CNT_EN
    check("idle_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
  endtask

  initial begin
    // Reset held with en=1: everything stays cleared.
    rst     = 1'b1;
    en      = 1'b1;
    ch_mask = 4'hF;
    dwell   = 4'd0;
    data    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_slc", 32'(slc), 32'd0);
    check("rst_svld", 32'(sample_vld), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_fvld", 32'(frame_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef MUX_SCAN_FRAME_CNT_EN
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    // Release: scan starts on the next edge.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("release_busy", 32'(busy), 32'd1);
    check("release_slc", 32'(slc), 32'd0);
    en = 1'b0;
    @(negedge clk);
    #1;
    check("release_idle", 32'(busy), 32'd0);

    // Directed scans.
    run_scan(4'hF, 0, 4'b1101, 12);
    run_scan(4'b1010, 2, 4'(~model_frame), 18);
    run_scan(4'b0100, 1, 4'b0100, 10);
    // Drop after two samples of a full-mask frame; frame must keep its previous value.
    run_scan(4'hF, 0, 4'b1011, 2);

    // Empty mask with en=1 never leaves idle.
    @(negedge clk);
    ch_mask = 4'h0;
    en      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("mask0_busy", 32'(busy), 32'd0);
      check("mask0_slc", 32'(slc), 32'd0);
      check("mask0_svld", 32'(sample_vld), 32'd0);
    end
    en = 1'b0;

    // 258 single-cycle frames: the frame counter wraps past 255.
    run_scan(4'b0001, 0, 4'b0001, 258);

    // Randomized scans.
    for (int r = 0; r < 10; r++) begin
      run_scan(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 4'($urandom),
               int'($urandom_range(1, 40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
